// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned DM_WORD_BYTES = 4;
  localparam int unsigned DM_DATA_W     = 8 * DM_WORD_BYTES;
  localparam int unsigned DM_ADDR_W     = 32;
  localparam int unsigned DM_BE_W       = DM_WORD_BYTES;
  localparam int unsigned DM_WCNT_W     = 4;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic                 write;
    logic [DM_ADDR_W-1:0] addr;
    logic [DM_DATA_W-1:0] wdata;
    logic [DM_BE_W-1:0]   be;
  } dm_req_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array: byte-masked synchronous write, registered read.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [DM_DATA_W-1:0] wr_data,
  input  logic [DM_BE_W-1:0]   wr_be,
  input  logic                 rd_en,
  input  logic                 rd_clr,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [DM_DATA_W-1:0] rd_data
);

  logic [DM_DATA_W-1:0] mem [DEPTH];

  // Merge enabled bytes into the addressed word; contents are never reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < DM_WORD_BYTES; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read register doubles as the response data holder; clear wins over load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder for the MEM stage (valid/ready request,
// held response). Optional fault checking is enabled by defining DMEM_ERR_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned IDX_W       = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [DM_ADDR_W-1:0] req_addr,
  input  logic [DM_DATA_W-1:0] req_wdata,
  input  logic [DM_BE_W-1:0]   req_be,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DM_DATA_W-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 busy
);

  dm_state_e            state;
  logic [DM_WCNT_W-1:0] wcnt;
  dm_req_t              lat_req;
  dm_req_t              cur_req;
  logic                 accept_c;
  logic                 commit_c;
  logic                 handshake_c;
  logic                 err_c;
  logic [IDX_W-1:0]     idx_c;

  // Request seen at the commit edge: live inputs when committing straight
  // from IDLE (zero-wait build), otherwise the latched copy.
  always_comb begin
    cur_req = lat_req;
    if (state == DM_IDLE) begin
      cur_req = '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};
    end
  end

  // Handshake, commit and fault decode.
  always_comb begin
    accept_c    = req_valid && req_ready;
    handshake_c = resp_valid && resp_ready;
    commit_c    = (accept_c && (WAIT_CYCLES == 0)) ||
                  ((state == DM_WAIT) && (wcnt == '0));
    idx_c       = cur_req.addr[IDX_W+1:2];
  end

`ifdef DMEM_ERR_EN
  // Misaligned or out-of-range word index faults.
  always_comb begin
    err_c = (cur_req.addr[1:0] != 2'b00) ||
            (cur_req.addr[DM_ADDR_W-1:2] >= (DM_ADDR_W-2)'(DEPTH));
  end
`else
  // Offset and high address bits are don't-care; the index wraps.
  logic unused_addr_bits;
  always_comb begin
    err_c            = 1'b0;
    unused_addr_bits = ^{cur_req.addr[1:0], cur_req.addr[DM_ADDR_W-1:IDX_W+2]};
  end
`endif

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= DM_IDLE;
      wcnt       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      lat_req    <= '0;
    end else begin
      case (state)
        DM_IDLE: begin
          if (accept_c) begin
            lat_req   <= cur_req;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state      <= DM_RESP;
              resp_valid <= 1'b1;
              resp_err   <= err_c;
            end else begin
              state <= DM_WAIT;
              wcnt  <= DM_WCNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        DM_WAIT: begin
          if (wcnt == '0) begin
            state      <= DM_RESP;
            resp_valid <= 1'b1;
            resp_err   <= err_c;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        DM_RESP: begin
          if (handshake_c) begin
            state      <= DM_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= DM_IDLE;
          wcnt       <= '0;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Storage; its read register is the response data output.
  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (commit_c && cur_req.write && !err_c),
    .wr_idx  (idx_c),
    .wr_data (cur_req.wdata),
    .wr_be   (cur_req.be),
    .rd_en   (commit_c && !cur_req.write && !err_c),
    .rd_clr  (handshake_c),
    .rd_idx  (idx_c),
    .rd_data (resp_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic against a word-array reference model; a second zero-wait instance
// exercises back-to-back throughput.
module tb_dmem_responder;

  localparam int unsigned WAITC = 2;

  logic        clock = 1'b0;
  logic        reset;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_resp_valid, z_resp_ready, z_resp_err, z_busy;
  logic [31:0] z_resp_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] z_ref   [256];

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH(256), .IDX_W(8), .WAIT_CYCLES(WAITC)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH(256), .IDX_W(8), .WAIT_CYCLES(0)) u_dut_z (
    .clock(clock), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
    .resp_err(z_resp_err), .busy(z_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One complete request: accept, wait states, held response, release.
  task automatic transact(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int hold);
    logic       e;
    logic [7:0] idx;
    logic [31:0] exp_rd;
    e      = ref_err(a);
    idx    = a[9:2];
    exp_rd = (wr || e) ? 32'h0 : ref_mem[idx];
    if (wr && !e) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ref_mem[idx][8*i +: 8] = wd[8*i +: 8];
      end
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
    resp_ready = 1'b0;
    step();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("req_ready_busy", 32'(req_ready), 32'd0);
    for (int w = 0; w < int'(WAITC); w++) begin
      check("resp_valid_wait", 32'(resp_valid), 32'd0);
      step();
    end
    check("resp_valid_rise", 32'(resp_valid), 32'd1);
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", 32'(resp_err), 32'(e));
    for (int h = 0; h < hold; h++) begin
      step();
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_rdata", resp_rdata, exp_rd);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    step();
    resp_ready = 1'b0;
    check("rel_resp_valid", 32'(resp_valid), 32'd0);
    check("rel_req_ready", 32'(req_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_rdata_clear", resp_rdata, 32'h0);
    check("rel_err_clear", 32'(resp_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        zw [6];
    logic [31:0] za [6];
    logic [31:0] zd [6];
    logic [31:0] zexp [6];
    int          k;

    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_resp_ready = 1'b0;
    repeat (3) step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_z_req_ready", 32'(z_req_ready), 32'd1);
    reset = 1'b1;
    step();

    // Give every word a known value.
    for (int i = 0; i < 256; i++) transact(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

    // Store then load, byte merge, empty mask.
    transact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    transact(1'b0, 32'h10, 32'h0, 4'h0, 0);
    transact(1'b1, 32'h10, 32'h00005500, 4'h2, 0);
    transact(1'b0, 32'h10, 32'h0, 4'hF, 0);
    transact(1'b1, 32'h10, 32'h11111111, 4'h0, 0);
    transact(1'b0, 32'h10, 32'h0, 4'h0, 0);

    // Backpressure on a load.
    transact(1'b0, 32'h10, 32'h0, 4'h0, 5);

    // Fault / wrap cases.
    transact(1'b0, 32'h13, 32'h0, 4'hF, 0);
    transact(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0);
    transact(1'b0, 32'h0, 32'h0, 4'hF, 0);

    // Reset mid-WAIT drops the store.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    step();
    req_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    #2;
    reset = 1'b1;
    step();
    check("postrst_req_ready", 32'(req_ready), 32'd1);
    check("postrst_resp_valid", 32'(resp_valid), 32'd0);
    transact(1'b0, 32'h20, 32'h0, 4'hF, 0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int          sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
      else               a = 32'($urandom_range(0, 255) * 4);
      transact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end

    // Zero-wait instance: back-to-back requests, one response every 2 cycles.
    for (int i = 0; i < 6; i++) begin
      zw[i] = (i < 3);
      za[i] = (i < 3) ? 32'(32'h40 + i * 4) : 32'(32'h40 + ((i + 1) % 3) * 4);
      zd[i] = $urandom;
      if (zw[i]) begin
        z_ref[za[i][9:2]] = zd[i];
        zexp[i] = 32'h0;
      end else begin
        zexp[i] = z_ref[za[i][9:2]];
      end
    end
    z_resp_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      check("z_req_ready", 32'(z_req_ready), (c % 2 == 0) ? 32'd1 : 32'd0);
      if (k < 6) begin
        z_req_valid = 1'b1; z_req_write = zw[k]; z_req_addr = za[k];
        z_req_wdata = zd[k]; z_req_be = 4'hF;
      end else begin
        z_req_valid = 1'b0;
      end
      step();
      if (c % 2 == 0) begin
        check("z_resp_valid", 32'(z_resp_valid), 32'd1);
        check("z_resp_rdata", z_resp_rdata, zexp[k]);
        check("z_resp_err", 32'(z_resp_err), 32'd0);
        k++;
      end else begin
        check("z_resp_gap", 32'(z_resp_valid), 32'd0);
      end
    end
    z_req_valid = 1'b0;
    step();
    check("z_idle_busy", 32'(z_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
